// File: rtl/nmcu_pkg.sv
// rtl/nmcu_pkg.sv - shared types and helpers for the PE array front end
package nmcu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    HOLD
  } pe_stream_state_e;

  localparam int PE_MAX_K = 256;

  // Extra register stages the widest skew line adds beyond the first.
  function automatic int skew_depth(input int rows, input int cols);
    return ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/pe_skew_line.sv
// rtl/pe_skew_line.sv - per-lane register delay line with settable reset value
module pe_skew_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the lane through DEPTH registers; stage 0 is the array input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pe_stream_ctrl.sv
// rtl/pe_stream_ctrl.sv - command-driven operand streaming and psum tile capture for the PE array
module pe_stream_ctrl
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PSUM_WIDTH    = 32,
  parameter int PE_ROWS       = 4,
  parameter int PE_COLS       = 4,
  parameter int MAX_K         = PE_MAX_K,
  parameter int ARRAY_LATENCY = PE_ROWS + PE_COLS + 1,
  parameter int SKEW_EN       = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cmd_valid_i,
  output logic                                   cmd_ready_o,
  input  logic [$clog2(MAX_K+1)-1:0]             cmd_k_len_i,
  input  logic                                   cmd_accum_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [DATA_WIDTH*PE_ROWS-1:0]          in_a_i,
  input  logic [DATA_WIDTH*PE_COLS-1:0]          in_b_i,
  output logic [DATA_WIDTH*PE_ROWS-1:0]          pe_a_o,
  output logic [DATA_WIDTH*PE_COLS-1:0]          pe_b_o,
  output logic [PE_ROWS-1:0]                     pe_accum_en_o,
  input  logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0]  pe_result_i,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0]  res_o,
  output logic                                   busy_o
);

  localparam int KW           = $clog2(MAX_K + 1);
  // Enough cycles for the last skewed beat to cross the array and settle.
  localparam int DRAIN_CYCLES = ARRAY_LATENCY + ((SKEW_EN != 0) ? skew_depth(PE_ROWS, PE_COLS) : 0);
  localparam int DCW          = $clog2(DRAIN_CYCLES + 1);

  pe_stream_state_e state, state_nxt;
  logic [KW-1:0]    beat_cnt, beat_cnt_nxt;
  logic [DCW-1:0]   drain_cnt, drain_cnt_nxt;
  logic             accum_q, accum_nxt;
  logic             first_beat, first_beat_nxt;
  logic             beat_fire;
  logic             capture;
  logic             en_beat;
  logic [KW-1:0]    k_sat;

  assign k_sat   = (cmd_k_len_i > KW'(MAX_K)) ? KW'(MAX_K) : cmd_k_len_i;
  // Only the very first beat of a non-accumulating command clears the psums.
  assign en_beat = !(first_beat && !accum_q);
  assign busy_o  = (state != IDLE);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      accum_q    <= 1'b0;
      first_beat <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
      accum_q    <= accum_nxt;
      first_beat <= first_beat_nxt;
    end
  end

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    drain_cnt_nxt  = drain_cnt;
    accum_nxt      = accum_q;
    first_beat_nxt = first_beat;
    cmd_ready_o    = 1'b0;
    in_ready_o     = 1'b0;
    res_valid_o    = 1'b0;
    beat_fire      = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accum_nxt = cmd_accum_i;
          if (k_sat != '0) begin
            state_nxt      = STREAM;
            beat_cnt_nxt   = k_sat;
            first_beat_nxt = 1'b1;
          end else begin
            // Zero-length command just snapshots the current array contents.
            state_nxt     = DRAIN;
            drain_cnt_nxt = DCW'(DRAIN_CYCLES - 1);
          end
        end
      end
      STREAM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          beat_fire      = 1'b1;
          first_beat_nxt = 1'b0;
          beat_cnt_nxt   = beat_cnt - KW'(1);
          if (beat_cnt == KW'(1)) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DCW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          drain_cnt_nxt = drain_cnt - DCW'(1);
        end
      end
      HOLD: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result tile register, loaded once the array has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_o <= '0;
    end else if (capture) begin
      res_o <= pe_result_i;
    end
  end

  // Row lanes carry operand plus accumulate enable; idle cycles feed zeros with enable high.
  for (genvar r = 0; r < PE_ROWS; r++) begin : g_row
    localparam int RD = (SKEW_EN != 0) ? r + 1 : 1;
    logic [DATA_WIDTH:0] din;
    logic [DATA_WIDTH:0] dout;
    assign din = beat_fire ? {en_beat, in_a_i[r*DATA_WIDTH +: DATA_WIDTH]}
                           : {1'b1, {DATA_WIDTH{1'b0}}};
    pe_skew_line #(
      .WIDTH  (DATA_WIDTH + 1),
      .DEPTH  (RD),
      .RST_VAL({1'b1, {DATA_WIDTH{1'b0}}})
    ) u_row_line (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din),
      .dout (dout)
    );
    assign pe_a_o[r*DATA_WIDTH +: DATA_WIDTH] = dout[DATA_WIDTH-1:0];
    assign pe_accum_en_o[r]                   = dout[DATA_WIDTH];
  end

  for (genvar c = 0; c < PE_COLS; c++) begin : g_col
    localparam int CD = (SKEW_EN != 0) ? c + 1 : 1;
    logic [DATA_WIDTH-1:0] din;
    assign din = beat_fire ? in_b_i[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    pe_skew_line #(
      .WIDTH  (DATA_WIDTH),
      .DEPTH  (CD),
      .RST_VAL('0)
    ) u_col_line (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din),
      .dout (pe_b_o[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// tb/tb_pe_stream_ctrl.sv - randomized self-checking bench for pe_stream_ctrl with a systolic array model
module tb_pe_stream_ctrl;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int PW = 32;
  localparam int EXP_LAT = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [8:0]           cmd_k_len;
  logic                 cmd_accum;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW*NR-1:0]     in_a;
  logic [DW*NC-1:0]     in_b;
  logic [DW*NR-1:0]     pe_a;
  logic [DW*NC-1:0]     pe_b;
  logic [NR-1:0]        pe_accum_en;
  logic [PW*NR*NC-1:0]  pe_result;
  logic                 res_valid;
  logic                 res_ready;
  logic [PW*NR*NC-1:0]  res;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  pe_stream_ctrl #(
    .DATA_WIDTH   (DW),
    .PSUM_WIDTH   (PW),
    .PE_ROWS      (NR),
    .PE_COLS      (NC),
    .MAX_K        (256),
    .ARRAY_LATENCY(4),
    .SKEW_EN      (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_k_len_i  (cmd_k_len),
    .cmd_accum_i  (cmd_accum),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .pe_a_o       (pe_a),
    .pe_b_o       (pe_b),
    .pe_accum_en_o(pe_accum_en),
    .pe_result_i  (pe_result),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_o        (res),
    .busy_o       (busy)
  );

  // Output-stationary systolic array: a and enable flow right, b flows down.
  logic [DW-1:0] am_a  [NR][NC];
  logic [DW-1:0] am_b  [NR][NC];
  logic          am_en [NR][NC];
  logic [PW-1:0] am_ps [NR][NC];
  logic [DW-1:0] ain   [NR][NC];
  logic [DW-1:0] bin   [NR][NC];
  logic          enin  [NR][NC];
  bit            am_clr = 1'b1;

  // Operand arriving at each PE this cycle.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      ain[r][0]  = pe_a[r*DW +: DW];
      enin[r][0] = pe_accum_en[r];
      for (int c = 1; c < NC; c++) begin
        ain[r][c]  = am_a[r][c-1];
        enin[r][c] = am_en[r][c-1];
      end
    end
    for (int c = 0; c < NC; c++) begin
      bin[0][c] = pe_b[c*DW +: DW];
      for (int r = 1; r < NR; r++) bin[r][c] = am_b[r-1][c];
    end
  end

  // MAC and forwarding registers of every PE.
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (am_clr) begin
          am_a[r][c]  <= '0;
          am_b[r][c]  <= '0;
          am_en[r][c] <= 1'b1;
          am_ps[r][c] <= '0;
        end else begin
          am_a[r][c]  <= ain[r][c];
          am_b[r][c]  <= bin[r][c];
          am_en[r][c] <= enin[r][c];
          am_ps[r][c] <= (enin[r][c] ? am_ps[r][c] : 32'd0) + 32'(ain[r][c]) * 32'(bin[r][c]);
        end
      end
    end
  end

  // Flatten psums onto the controller's result input.
  always_comb begin
    pe_result = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        pe_result[(r*NC+c)*PW +: PW] = am_ps[r][c];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected array contents as a matrix: sum over beats of a[r]*b[c].
  logic [31:0] ref_t [NR*NC];
  logic [15:0] qa [$];
  logic [15:0] qb [$];

  task automatic send_cmd(input int k_cmd, input bit acc, input int bubble_pct,
                          input int bubble_at, input int hold_cycles, output int lat_first);
    int k_eff, n, guard, t_last, t_first;
    bit fire, bubbled;
    logic [15:0] av, bv;
    logic [31:0] exp_t [NR*NC];
    k_eff = (k_cmd > 256) ? 256 : k_cmd;
    for (int i = 0; i < NR*NC; i++) exp_t[i] = (acc || k_eff == 0) ? ref_t[i] : 32'd0;
    for (int b = 0; b < k_eff; b++) begin
      av = qa[b];
      bv = qb[b];
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          exp_t[r*NC+c] += 32'(av[r*DW +: DW]) * 32'(bv[c*DW +: DW]);
    end

    cmd_valid = 1'b1;
    cmd_k_len = 9'(k_cmd);
    cmd_accum = acc;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    t_last  = cyc;
    t_first = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;

    n = 0;
    guard = 0;
    bubbled = 1'b0;
    while (n < k_eff && guard < 4*k_eff + 20) begin
      in_valid = 1'b1;
      if (n == bubble_at && !bubbled) begin
        in_valid = 1'b0;
        bubbled  = 1'b1;
      end else if ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
      end
      if (in_valid) begin
        in_a = qa[n];
        in_b = qb[n];
      end else begin
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
      fire = in_valid && in_ready;
      if (fire) begin
        if (n == 0) t_first = cyc;
        t_last = cyc;
        n++;
      end
      @(negedge clk);
      guard++;
      if (fire && n == 1) check_eq("first_accum_en_row0", 32'(pe_accum_en[0]), 32'(acc));
    end
    in_valid = 1'b0;
    check_eq("beats_accepted", 32'(n), 32'(k_eff));
    check_eq("in_ready_after_last", 32'(in_ready), 32'd0);

    guard = 0;
    while (!res_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("res_valid_rise", 32'(res_valid), 32'd1);
    check_eq("res_latency", 32'(cyc - t_last), 32'(EXP_LAT));
    lat_first = cyc - t_first;
    for (int i = 0; i < NR*NC; i++) check_eq("res_tile", res[i*PW +: PW], exp_t[i]);

    res_ready = 1'b0;
    for (int h = 0; h < hold_cycles; h++) @(negedge clk);
    if (hold_cycles > 0) begin
      check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_res_valid", 32'(res_valid), 32'd1);
      for (int i = 0; i < NR*NC; i++) check_eq("hold_tile", res[i*PW +: PW], exp_t[i]);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("idle_res_valid", 32'(res_valid), 32'd0);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < NR*NC; i++) ref_t[i] = exp_t[i];
  endtask

  initial begin
    int lat0, lat1, latx;
    bit seen;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_k_len = '0;
    cmd_accum = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NR*NC; i++) ref_t[i] = 32'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_accum_en", 32'(pe_accum_en), 32'd3);
    check_eq("rst_pe_a", 32'(pe_a), 32'd0);
    check_eq("rst_res", res[31:0] | res[63:32] | res[95:64] | res[127:96], 32'd0);
    am_clr = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // A = beats a={1,2},{3,4}; B = beats b={5,6},{7,8}.
    qa = '{16'h0201, 16'h0403};
    qb = '{16'h0605, 16'h0807};
    send_cmd(2, 1'b0, 0, -1, 0, lat0);
    check_eq("ab_00", res[0*PW +: PW], 32'd26);
    check_eq("ab_01", res[1*PW +: PW], 32'd30);
    check_eq("ab_10", res[2*PW +: PW], 32'd38);
    check_eq("ab_11", res[3*PW +: PW], 32'd44);

    send_cmd(2, 1'b0, 0, 1, 0, lat1);
    check_eq("bubble_delay", 32'(lat1), 32'(lat0 + 1));

    send_cmd(2, 1'b1, 0, -1, 10, latx);
    check_eq("acc_00", res[0*PW +: PW], 32'd52);
    check_eq("acc_01", res[1*PW +: PW], 32'd60);
    check_eq("acc_10", res[2*PW +: PW], 32'd76);
    check_eq("acc_11", res[3*PW +: PW], 32'd88);

    send_cmd(0, 1'b0, 0, -1, 2, latx);

    // Zero-length command interrupted by reset while draining.
    cmd_valid = 1'b1;
    cmd_k_len = 9'd0;
    cmd_accum = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("drain_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_res_valid", 32'(res_valid), 32'd0);
    check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst_accum_en", 32'(pe_accum_en), 32'd3);
    check_eq("midrst_res", res[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    check_eq("postrst_quiet", 32'(seen), 32'd0);

    // Oversized command saturates to 256 beats.
    qa.delete();
    qb.delete();
    for (int i = 0; i < 256; i++) begin
      qa.push_back(16'($urandom));
      qb.push_back(16'($urandom));
    end
    send_cmd(300, 1'b0, 10, -1, 1, latx);

    for (int t = 0; t < 20; t++) begin
      int k;
      qa.delete();
      qb.delete();
      k = $urandom_range(6);
      for (int i = 0; i < k; i++) begin
        qa.push_back(16'($urandom));
        qb.push_back(16'($urandom));
      end
      send_cmd(k, 1'($urandom_range(1)), 30, -1, $urandom_range(3), latx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_stream_ctrl.md
Name: pe_stream_ctrl

Overview:
- Next-generation PE array front end: command-driven streaming controller for a PE_ROWS x PE_COLS systolic array.
- Accepts a K-beat matmul command and its operand stream, optionally applies systolic input skew, and drives the array's operand and accumulate-enable inputs.
- Drains a parametrised pipeline, captures the full psum tile, and returns it over a valid/ready result handshake.
- Sits between the control unit and the existing pe_array.
- Replaces fixed-latency, valid-shift-register done signalling with explicit beat counting, stall tolerance and backpressure.

Parameters:
- DATA_WIDTH, 8, operand width
- PSUM_WIDTH, 32, partial-sum width
- PE_ROWS, 4, array rows (number of a lanes)
- PE_COLS, 4, array columns (number of b lanes)
- MAX_K, 256, maximum beats per command
- ARRAY_LATENCY, PE_ROWS+PE_COLS+1, cycles from array input register to settled result
- SKEW_EN, 1, 1: delay row r by r cycles and column c by c cycles

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_k_len_i  in  $clog2(MAX_K+1)  number of beats
- cmd_accum_i  in  1  1: accumulate onto existing psums; 0: clear on first beat
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat ready
- in_a_i  in  DATA_WIDTH x PE_ROWS  row operands
- in_b_i  in  DATA_WIDTH x PE_COLS  column operands
- pe_a_o  out  DATA_WIDTH x PE_ROWS  to array
- pe_b_o  out  DATA_WIDTH x PE_COLS  to array
- pe_accum_en_o  out  PE_ROWS  to array
- pe_result_i  in  PSUM_WIDTH x PE_ROWS x PE_COLS  from array
- res_valid_o  out  1  result tile valid
- res_ready_i  in  1  result accepted
- res_o  out  PSUM_WIDTH x PE_ROWS x PE_COLS  captured tile
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; cmd_ready_o=1; in_ready_o=0; res_valid_o=0; busy_o=0; res_o, pe_a_o, pe_b_o, all skew stages = 0; pe_accum_en_o all 1.
- FSM states: IDLE, STREAM, DRAIN, HOLD.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch k_len and accum.
  - k_len>0 -> STREAM with beat_cnt=k_len, first_beat=1.
  - k_len==0 -> DRAIN directly; the captured tile is the current array contents.
- STREAM:
  - in_ready_o=1.
  - Accepted beat: operands registered into the skew stage-0 registers. Accumulate enable is 0 on the first beat when accum=0, otherwise 1. beat_cnt decrements.
  - Cycle with no in_valid_i (bubble): zeros injected with accumulate enable 1; psums unchanged; beat_cnt holds.
  - Acceptance of the beat that brings beat_cnt to 0 -> DRAIN, drain_cnt=DRAIN_CYCLES-1.
  - No beats are accepted in the last-beat cycle's successor.
- Skew:
  - SKEW_EN=1: row r operand and accumulate enable pass through r extra register stages; column c operand through c stages.
  - SKEW_EN=0: single register stage for all lanes.
  - Zeros and accumulate enable 1 shift in behind the data.
- DRAIN_CYCLES = ARRAY_LATENCY + (SKEW_EN ? max(PE_ROWS,PE_COLS)-1 : 0).
- DRAIN:
  - Inputs are zeros with accumulate enable 1.
  - drain_cnt decrements each cycle.
  - At 0: res_o <= pe_result_i, res_valid_o=1 from the next cycle, -> HOLD.
- HOLD:
  - res_o stable, res_valid_o=1.
  - res_valid_o & res_ready_i -> IDLE, res_valid_o=0 next cycle.
  - A new command cannot be accepted in the same cycle; the first acceptance is the cycle after.
- Latency: last beat accepted at cycle T -> res_valid_o rises at T+DRAIN_CYCLES+1.
- cmd_k_len_i > MAX_K is saturated to MAX_K.
- Reset asserted mid-operation returns all outputs to reset values immediately; in-flight data is discarded.

Decomposition:
- nmcu_pkg gains:
  - typedef enum logic [1:0] pe_stream_state_e {IDLE, STREAM, DRAIN, HOLD}
  - localparam PE_MAX_K = 256
  - function skew_depth(rows, cols)
- One sub-module, pe_skew_line (params WIDTH, DEPTH): a per-lane delay line with DEPTH>=1 register stages and reset value parameter RST_VAL. Instantiated per row (operand+accum, RST_VAL accum=1) and per column.

Test Plan:
- All scenarios run with PE_ROWS=PE_COLS=2, ARRAY_LATENCY=4, SKEW_EN=1 (DRAIN_CYCLES=5) against a behavioural array model in the bench.
- Reset: hold rst_n=0 -> cmd_ready_o=1, res_valid_o=0, pe_accum_en_o=2'b11, res_o all 0.
- k_len=2, accum=0, a={1,2}/{3,4}, b={5,6}/{7,8} back-to-back -> row0 accum_en=0 on first skewed beat; res_valid_o exactly 6 cycles after the second beat; res_o = A*B = {{26,30},{38,44}}.
- Same command with one-cycle in_valid_i bubble between beats -> identical res_o; res_valid_o delayed by exactly 1 cycle.
- Second command k_len=2, accum=1, same data, issued after HOLD -> res_o doubles to {{52,60},{76,88}}.
- res_ready_i held low 10 cycles in HOLD -> res_o stable, cmd_ready_o=0, in_ready_o=0. Release -> IDLE next cycle.
- k_len=0 -> STREAM skipped, res_valid_o 6 cycles after acceptance. rst_n pulse mid-DRAIN -> res_valid_o stays 0, busy_o=0.
